// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store requesters
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic       OWN_F      = 1'b0;
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner;
    logic       r_last;
    logic [7:0] r_cnt;

    logic w_f_elig;
    logic w_d_elig;
    logic w_grant;
    logic w_grant_d;
    logic w_done;
    logic w_tmo;

    // A requester being acked this cycle is still holding req; keep it out of the next grant.
    always_comb begin
        w_f_elig    = f_req & ~(f_ack | f_err);
        w_d_elig    = d_req & ~(d_ack | d_err);
        w_grant     = w_f_elig | w_d_elig;
        w_grant_d   = w_d_elig & (~w_f_elig | (r_last == OWN_F));
        w_done      = (r_state == S_BUSY) & m_ready;
        w_tmo       = (r_state == S_BUSY) & ~m_ready & (r_cnt == LP_TO_LAST);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done || w_tmo) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_F;
            r_last  <= OWN_F;
            r_cnt   <= 8'd0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            f_rdata <= '0;
            f_ack   <= 1'b0;
            f_err   <= 1'b0;
            d_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            f_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_grant) begin
                        m_en    <= 1'b1;
                        r_owner <= w_grant_d;
                        r_last  <= w_grant_d;
                        if (w_grant_d) begin
                            m_addr  <= d_addr;
                            m_we    <= d_we;
                            m_wdata <= d_wdata;
                        end else begin
                            m_addr  <= f_addr;
                            m_we    <= 1'b0;
                            m_wdata <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        m_en <= 1'b0;
                        m_we <= 1'b0;
                        if (r_owner == OWN_F) begin
                            f_ack   <= 1'b1;
                            f_rdata <= m_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end
                    end else if (w_tmo) begin
                        m_en <= 1'b0;
                        m_we <= 1'b0;
                        if (r_owner == OWN_F) begin
                            f_ack   <= 1'b1;
                            f_err   <= 1'b1;
                            f_rdata <= '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic [31:0] f_rdata;
    logic        f_ack, f_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack, d_err;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] other;
        logic        err;
        int          cyc;
    } txn_t;

    txn_t        grant_q[$];
    txn_t        done_q[$];
    logic [31:0] f_rd_exp = '0;
    logic [31:0] d_rd_exp = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          mem_delay = 1;
    int          mem_k = 0;
    logic        idle_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // delay 0 means the memory never answers
    task automatic expect_txn(input logic is_d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay, input bit completes);
        txn_t t;
        t.is_d  = is_d;
        t.we    = is_d & we;
        t.addr  = addr;
        t.wdata = is_d ? wdata : 32'h0;
        t.err   = (delay == 0);
        t.cyc   = (delay == 0) ? TO : delay;
        t.other = is_d ? f_rd_exp : d_rd_exp;
        if (t.err)      t.rdata = 32'h0;
        else if (t.we)  t.rdata = d_rd_exp;
        else            t.rdata = mem_fn(addr);
        grant_q.push_back(t);
        if (completes) begin
            if (is_d) d_rd_exp = t.rdata;
            else      f_rd_exp = t.rdata;
            done_q.push_back(t);
        end
    endtask

    task automatic run_req(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bit got = 1'b0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (is_d ? d_ack : f_ack) got = 1'b1;
        end
        if (is_d) d_req = 1'b0;
        else      f_req = 1'b0;
        check(is_d ? "d_ack_wait" : "f_ack_wait", {31'b0, got}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (m_en) begin
            mem_k   = mem_k + 1;
            m_ready = (mem_delay != 0) && (mem_k >= mem_delay);
            m_rdata = mem_fn(m_addr);
        end else begin
            mem_k   = 0;
            m_ready = idle_ready;
            m_rdata = 32'hBAD0BAD0;
        end
    end

    logic prev_m_en = 1'b0;
    logic prev_f_ack = 1'b0;
    logic prev_d_ack = 1'b0;
    int   busy_cnt = 0;
    txn_t cur_g;
    txn_t cur_d;

    always @(negedge clk) begin
        if (m_en) begin
            if (!prev_m_en) begin
                busy_cnt = 1;
                if (grant_q.size() == 0) check("unexpected_grant", 32'd1, 32'd0);
                else begin
                    cur_g = grant_q.pop_front();
                    check("grant_addr", m_addr, cur_g.addr);
                    check("grant_we", {31'b0, m_we}, {31'b0, cur_g.we});
                    check("grant_wdata", m_wdata, cur_g.wdata);
                end
            end else begin
                busy_cnt++;
                check("busy_addr_hold", m_addr, cur_g.addr);
            end
        end
        if (f_ack | d_ack | f_err | d_err) begin
            check("ack_exclusive", {30'b0, f_ack & d_ack, f_err & d_err}, 32'd0);
            if ((f_ack && prev_f_ack) || (d_ack && prev_d_ack)) check("ack_pulse", 32'd1, 32'd0);
            if (done_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
                cur_d = done_q.pop_front();
                check("ack_owner", {30'b0, f_ack, d_ack}, cur_d.is_d ? 32'd1 : 32'd2);
                check("ack_err", {30'b0, f_err, d_err},
                      cur_d.err ? (cur_d.is_d ? 32'd1 : 32'd2) : 32'd0);
                check("ack_rdata", cur_d.is_d ? d_rdata : f_rdata, cur_d.rdata);
                check("other_rdata", cur_d.is_d ? f_rdata : d_rdata, cur_d.other);
                check("busy_cycles", busy_cnt, cur_d.cyc);
                check("m_en_off", {30'b0, m_en, m_we}, 32'd0);
            end
        end
        prev_m_en  = m_en;
        prev_f_ack = f_ack;
        prev_d_ack = d_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_is_d, r_we;
        logic [31:0] r_addr, r_wdata;
        int          r_dly;

        repeat (3) @(negedge clk);
        check("rst_m_en", {31'b0, m_en}, 32'd0);
        check("rst_m_we", {31'b0, m_we}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_acks", {28'b0, f_ack, f_err, d_ack, d_err}, 32'd0);
        check("rst_f_rdata", f_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b1;

        idle_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_ignored", {29'b0, m_en, f_ack, d_ack}, 32'd0);
        end
        idle_ready = 1'b0;
        @(negedge clk);

        mem_delay = 1;
        expect_txn(1'b1, 1'b0, 32'h40, 32'hCAFE0000, 1, 1'b1);
        expect_txn(1'b0, 1'b0, 32'h80, 32'h0, 1, 1'b1);
        expect_txn(1'b1, 1'b0, 32'h40, 32'hCAFE0000, 1, 1'b1);
        expect_txn(1'b0, 1'b0, 32'h80, 32'h0, 1, 1'b1);
        fork
            begin
                run_req(1'b1, 1'b0, 32'h40, 32'hCAFE0000);
                run_req(1'b1, 1'b0, 32'h40, 32'hCAFE0000);
            end
            begin
                run_req(1'b0, 1'b0, 32'h80, 32'h0);
                run_req(1'b0, 1'b0, 32'h80, 32'h0);
            end
        join
        repeat (2) @(negedge clk);

        mem_delay = 2;
        expect_txn(1'b0, 1'b0, 32'h10, 32'h0, 2, 1'b1);
        run_req(1'b0, 1'b0, 32'h10, 32'h0);

        mem_delay = 1;
        expect_txn(1'b1, 1'b1, 32'h20, 32'h12345678, 1, 1'b1);
        run_req(1'b1, 1'b1, 32'h20, 32'h12345678);

        mem_delay = 0;
        expect_txn(1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b1);
        run_req(1'b1, 1'b0, 32'h30, 32'h0);

        mem_delay = TO;
        expect_txn(1'b1, 1'b0, 32'h34, 32'h0, TO, 1'b1);
        run_req(1'b1, 1'b0, 32'h34, 32'h0);

        for (int i = 0; i < 6; i++) begin
            r_is_d  = 1'($urandom_range(0, 1));
            r_we    = r_is_d & 1'($urandom_range(0, 1));
            r_addr  = 32'h100 + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            r_wdata = $urandom;
            r_dly   = int'($urandom_range(1, TO));
            mem_delay = r_dly;
            expect_txn(r_is_d, r_we, r_addr, r_wdata, r_dly, 1'b1);
            run_req(r_is_d, r_we, r_addr, r_wdata);
        end

        mem_delay = 0;
        expect_txn(1'b0, 1'b0, 32'h50, 32'h0, 0, 1'b0);
        f_addr = 32'h50;
        f_req  = 1'b1;
        for (int i = 0; i < 10 && !m_en; i++) @(negedge clk);
        check("abort_granted", {31'b0, m_en}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_m_en_async", {31'b0, m_en}, 32'd0);
        check("abort_rdata_cleared", f_rdata | d_rdata, 32'd0);
        f_rd_exp = '0;
        d_rd_exp = '0;
        @(negedge clk);
        check("abort_no_ack", {30'b0, f_ack, d_ack}, 32'd0);
        rst = 1'b1;
        mem_delay = 1;
        expect_txn(1'b0, 1'b0, 32'h50, 32'h0, 1, 1'b1);
        run_req(1'b0, 1'b0, 32'h50, 32'h0);

        repeat (4) @(negedge clk);
        check("grant_q_empty", grant_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum BUSY cycles waiting for m_ready (range 1..255).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous reset, active-low.
REQ-006 SHALL have ports f_req in 1 (fetch request), f_addr in ADDR_W, f_rdata out DATA_W, f_ack out 1, f_err out 1.
REQ-007 SHALL have ports d_req in 1 (load/store request), d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_rdata out DATA_W, d_ack out 1, d_err out 1.
REQ-008 SHALL have ports m_en out 1, m_we out 1, m_addr out ADDR_W, m_wdata out DATA_W, m_rdata in DATA_W, m_ready in 1 (single-port memory side).

Function
REQ-009 SHALL share one memory port between the fetch (F) and load/store (D) requesters, one transaction at a time.
REQ-010 Requester SHALL hold req, addr, we, wdata stable until its ack; arbiter behaviour is undefined otherwise.
REQ-011 SHALL implement FSM states IDLE and BUSY plus an owner register (F/D) and last_grant register (F/D).
REQ-012 IDLE: at an edge with an eligible request, SHALL latch winner's addr/we/wdata onto m_addr/m_we/m_wdata, assert m_en, set owner, go BUSY.
REQ-013 Only one eligible request -> that requester wins.
REQ-014 Both eligible -> SHALL grant the requester not equal to last_grant (round-robin); last_grant updates to winner on grant.
REQ-015 F grants SHALL drive m_we=0 and m_wdata=0.
REQ-016 A requester whose ack or err is high in the current cycle SHALL be ineligible at the next edge (no double grant from a held req).
REQ-017 BUSY: m_en, m_we, m_addr, m_wdata SHALL stay constant; a cycle counter (8 bits) SHALL increment each BUSY cycle from 0.
REQ-018 BUSY with m_ready=1 at an edge: SHALL go IDLE, deassert m_en/m_we, pulse owner's ack for exactly one cycle; for reads SHALL load owner's rdata with m_rdata; for writes rdata SHALL hold its prior value.
REQ-019 BUSY with counter reaching TIMEOUT and m_ready=0: SHALL go IDLE, deassert m_en, pulse owner's ack and err together for one cycle, load owner's rdata with 0.
REQ-020 m_ready and timeout at the same edge: m_ready SHALL win (normal completion, err=0).
REQ-021 m_ready while IDLE SHALL be ignored.
REQ-022 Minimum latency: req sampled at edge N -> m_en high after N; m_ready high at edge N+1 -> ack high during cycle after N+1; next grant no earlier than edge N+2.
REQ-023 f_rdata/d_rdata SHALL hold value until that requester's next completion.
REQ-024 ack and err SHALL never be high for both requesters in the same cycle.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, owner=F, last_grant=F, counter=0, and all outputs (m_*, *_ack, *_err, *_rdata) to 0.
REQ-026 Reset mid-BUSY SHALL abort the transaction with no ack/err; after rst=1, pending requests arbitrate from IDLE.
REQ-027 With both requesting first after reset, D SHALL win (last_grant=F).

Verification
REQ-028 Single F read: f_req=1, f_addr=0x10, m_ready=1 two cycles after m_en, m_rdata=0xDEADBEEF -> m_addr=0x10, m_we=0, one-cycle f_ack, f_rdata=0xDEADBEEF, d_ack=0.
REQ-029 D write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678, d_ack pulse, d_rdata unchanged.
REQ-030 Contention: f_req and d_req held for 4 transactions after reset, m_ready immediate -> grant order D,F,D,F; each req held only until its ack yields no extra grant.
REQ-031 Timeout: TIMEOUT=4, D read, m_ready=0 -> d_ack=d_err=1 for one cycle after 4 BUSY cycles, d_rdata=0, m_en low; m_ready on the 4th cycle instead -> err=0, data captured.
REQ-032 Reset mid-BUSY: rst=0 while m_en=1 -> m_en=0 immediately (before next clk edge), no ack; release rst with f_req=1 -> F granted normally.
